sbox_gf_inverse_seq: RTL

Sequential AES SubBytes engine that sits directly downstream of the GF(2^8) multiply/reduce stage. It takes one byte per transaction and computes its multiplicative inverse modulo x^8+x^4+x^3+x+1 (0x11B) as x^254 by iterated square-and-multiply, one reduced GF(2^8) product per clock. It then applies the AES affine transform and presents the S-box byte on a valid/ready output. It gives the cipher a small-area alternative to a 256-entry ROM S-box.

---
 rtl/sbox_gf_inverse_seq_if.sv | 34 +++
 rtl/sbox_gf_inverse_seq.sv | 131 +++++++++++++
 2 files changed

// File: rtl/sbox_gf_inverse_seq_if.sv
// Byte-in / byte-out handshake bundle for the sequential S-box.
// Carries the inv select only when SBOX_INV_EN is defined.
interface sbox_gf_inverse_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
`ifdef SBOX_INV_EN
  logic       inv;
`endif
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       busy;

`ifdef SBOX_INV_EN
  modport master (
    output in_valid, in_byte, inv, out_ready,
    input  in_ready, out_valid, out_byte, busy
  );
  modport slave (
    input  in_valid, in_byte, inv, out_ready,
    output in_ready, out_valid, out_byte, busy
  );
`else
  modport master (
    output in_valid, in_byte, out_ready,
    input  in_ready, out_valid, out_byte, busy
  );
  modport slave (
    input  in_valid, in_byte, out_ready,
    output in_ready, out_valid, out_byte, busy
  );
`endif
endinterface

// File: rtl/sbox_gf_inverse_seq.sv
// AES S-box via x^254 square-and-multiply over GF(2^8), one product per clock.
// SBOX_INV_EN adds the inverse S-box (inverse affine on input, bypass on output).
module sbox_gf_inverse_seq (
  input  logic                  clk,
  input  logic                  rst,
  sbox_gf_inverse_seq_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE, SQR, MUL, AFFINE, DONE
  } state_t;

  state_t     state;
  logic [7:0] base;
  logic [7:0] acc;
  logic [2:0] cnt;
  logic [7:0] out_q;
  logic       ov_q;
  logic [7:0] opb;
  logic [7:0] prod;
  logic [7:0] in_map;
`ifdef SBOX_INV_EN
  logic       mode;
`endif

  function automatic logic [7:0] gfmul(
    input logic [7:0] p,
    input logic [7:0] q
  );
    logic [7:0] r;
    logic [7:0] a;
    r = 8'h00;
    a = p;
    for (int i = 0; i < 8; i++) begin
      if (q[i]) r = r ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(
    input logic [7:0] a
  );
    return a
      ^ {a[6:0], a[7]}
      ^ {a[5:0], a[7:6]}
      ^ {a[4:0], a[7:5]}
      ^ {a[3:0], a[7:4]}
      ^ 8'h63;
  endfunction

`ifdef SBOX_INV_EN
  function automatic logic [7:0] inv_affine(
    input logic [7:0] a
  );
    return {a[1:0], a[7:2]}
      ^ {a[4:0], a[7:5]}
      ^ {a[6:0], a[7]}
      ^ 8'h05;
  endfunction

  assign in_map = bus.inv
    ? inv_affine(bus.in_byte)
    : bus.in_byte;
`else
  assign in_map = bus.in_byte;
`endif

  // One shared multiplier: squares in SQR, multiplies by base in MUL.
  assign opb  = (state == MUL) ? base : acc;
  assign prod = gfmul(acc, opb);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      base  <= 8'h00;
      acc   <= 8'h00;
      cnt   <= 3'd0;
      out_q <= 8'h00;
      ov_q  <= 1'b0;
`ifdef SBOX_INV_EN
      mode  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            base  <= in_map;
            acc   <= in_map;
            cnt   <= 3'd0;
            state <= SQR;
`ifdef SBOX_INV_EN
            mode  <= bus.inv;
`endif
          end
        end
        SQR: begin
          acc   <= prod;
          state <= (cnt == 3'd6) ? AFFINE : MUL;
        end
        MUL: begin
          acc   <= prod;
          cnt   <= cnt + 3'd1;
          state <= SQR;
        end
        AFFINE: begin
`ifdef SBOX_INV_EN
          out_q <= mode ? acc : affine(acc);
`else
          out_q <= affine(acc);
`endif
          ov_q  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            ov_q  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == SQR)
                      || (state == MUL)
                      || (state == AFFINE);
  assign bus.out_valid = ov_q;
  assign bus.out_byte  = out_q;
endmodule
